mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Responder for the CPU's split instruction/data memory ports. It accepts requests on both ports and serializes them onto one shared physical memory port. It is the far end of the `inst_mem_*` and `data_mem_*` handshakes, and it sits between the `cpu` top and the cache/physical memory. Each CPU request gets exactly one downstream transaction and exactly one single-cycle `*_resp` pulse.

## Interface
- STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits. Used only with DATA_PRIORITY_EN.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- inst_mem_address  input  32  instruction request address.
- inst_mem_read, inst_mem_write  input  1  instruction request strobes; held until inst_mem_resp.
- inst_mem_byte_enable  input  4  byte lanes.
- inst_mem_wdata  input  32  write data.
- inst_mem_rdata  output  32  read data; valid while inst_mem_resp=1.
- inst_mem_resp  output  1  one-cycle completion pulse.
- data_mem_address, data_mem_read, data_mem_write, data_mem_byte_enable, data_mem_wdata, data_mem_rdata, data_mem_resp: same widths, directions and meaning for the data port.
- pmem_address  output  32  downstream address.
- pmem_read, pmem_write  output  1  downstream strobes; held until pmem_resp.
- pmem_byte_enable  output  4  downstream byte lanes.
- pmem_wdata  output  32  downstream write data.
- pmem_rdata  input  32  downstream read data; valid with pmem_resp.
- pmem_resp  input  1  downstream completion.

## Operation
- FSM states are IDLE, BUSY_INST, BUSY_DATA, DONE_INST and DONE_DATA.
- A port is pending when its read or write strobe is 1. If both strobes are 1, the request is a write and the read is ignored.
- IDLE
  - With no pending port, stay in IDLE.
  - Otherwise pick a winner.
  - Latch that port's address, byte_enable, wdata and read/write type into the pmem_* output registers.
  - Go to BUSY_x.
- BUSY_x
  - pmem_read or pmem_write is held at 1 with stable address, byte enables and data.
  - On pmem_resp: capture pmem_rdata, clear the pmem strobes, and go to DONE_x.
- DONE_x
  - x_mem_resp=1 for exactly this cycle; x_mem_rdata is the captured data.
  - Next state is IDLE.
- Port changes after grant: if the CPU drops or changes the request during BUSY_x, the latched transaction still completes and the resp pulse is still issued.
- pmem_resp is ignored in IDLE and DONE_x.
- *_rdata holds its last captured value when resp=0. For writes, it is undefined but stable.
- Tie-break (both ports pending in IDLE) is per Configuration.

## Timing
- Reset values: state=IDLE; all pmem_* outputs, *_resp and *_rdata are 0; last_grant=DATA, so the first tie goes to INST; starve_cnt=0.
- Reset applied mid-transaction clears the pmem strobes asynchronously, the same cycle, and no resp is issued.
- Request seen in IDLE at edge 0 → pmem strobe asserted from edge 0.
- pmem_resp sampled at edge k → *_resp high from edge k to edge k+1 → IDLE at edge k+1.
- The earliest re-arbitration is the edge after DONE. A CPU that deasserts on resp is therefore never re-granted stale.
- Minimum CPU latency is 2 cycles, when pmem_resp arrives in the first BUSY cycle.
- Throughput is one transaction per (downstream latency + 2) cycles.

## Configuration
- DATA_PRIORITY_EN undefined:
  - Round-robin tie-break: grant the port other than last_grant.
  - last_grant updates on every grant.
- DATA_PRIORITY_EN defined:
  - The data port wins ties.
  - starve_cnt counts consecutive data grants made while inst is pending. It saturates at STARVE_LIMIT.
  - When starve_cnt==STARVE_LIMIT and inst is pending, inst wins and the counter clears.
  - The counter also clears on any inst grant, and on any data grant with inst not pending.
  - starve_cnt is 3 bits wide, clog2(STARVE_LIMIT+1).

## Structure
- Package mem_arb_types:
  - enum arb_state_t for the five states.
  - enum arb_port_t {PORT_INST, PORT_DATA}.
  - A struct mem_req_t holding address, byte_enable, wdata and a write flag.
- Sub-module mem_arb_select: combinational winner selection from the two pending flags, last_grant and starve_cnt. It holds the DATA_PRIORITY_EN conditional.
- The top holds the FSM, the request/response registers and the counters.

## Test plan
- Single inst read at 0x0000_0060, pmem_resp after 3 cycles with rdata 0xDEAD_BEEF → inst_mem_resp one cycle, inst_mem_rdata 0xDEAD_BEEF; data_mem_resp stays 0.
- Data write to 0x0000_1004, be 4'b0011, wdata 0x1234_5678 → pmem_write=1 with those exact values held stable until pmem_resp; data_mem_resp pulses once.
- Both ports pending continuously, macro off → grants alternate INST, DATA, INST, DATA.
- Same stimulus, macro on, STARVE_LIMIT=4 → grant order DATA×4, INST, then DATA×4 again.
- CPU drops inst_mem_read mid-BUSY → downstream read completes and inst_mem_resp still pulses exactly once.
- rst=0 while pmem_read=1 → pmem_read=0 immediately; after release, state is IDLE and no resp is emitted.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_types: shared types for the split instruction/data memory port
// arbiter.
//   arb_state_t : the arbiter FSM states
//   arb_port_t  : identifies the instruction or data CPU port
//   mem_req_t   : one latched downstream request (address, lanes, data, type)
//   pack_req()  : builds a mem_req_t from a port's raw request signals
package mem_arb_types;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_INST,
    BUSY_DATA,
    DONE_INST,
    DONE_DATA
  } arb_state_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } arb_port_t;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic        write;
  } mem_req_t;

  // A request with both strobes set is a write, so only the write strobe
  // matters when forming the request type.
  function automatic mem_req_t pack_req(input logic [31:0] address,
                                        input logic [3:0]  byte_enable,
                                        input logic [31:0] wdata,
                                        input logic        write);
    mem_req_t r;
    r.address     = address;
    r.byte_enable = byte_enable;
    r.wdata       = wdata;
    r.write       = write;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select: combinational winner selection between the instruction
// and data ports. Only meaningful when at least one port is pending.
//
// Configuration macro: DATA_PRIORITY_EN
//   undefined : round-robin on ties, the port other than last_grant wins
//   defined   : data wins ties unless the starvation limit has been reached
//
// Ports:
//   inst_pend  in   instruction port has a request
//   data_pend  in   data port has a request
//   at_limit   in   (DATA_PRIORITY_EN) starve counter equals its limit
//   last_grant in   (default build) port granted most recently
//   grant      out  winning port
module mem_arb_select
  import mem_arb_types::*;
(
  input  logic      inst_pend,
  input  logic      data_pend,
`ifdef DATA_PRIORITY_EN
  input  logic      at_limit,
`else
  input  arb_port_t last_grant,
`endif
  output arb_port_t grant
);

  always_comb begin
    // NOTE: the output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    grant = PORT_INST;
    if (inst_pend && data_pend) begin
`ifdef DATA_PRIORITY_EN
      grant = at_limit ? PORT_INST : PORT_DATA;
`else
      grant = (last_grant == PORT_DATA) ? PORT_INST : PORT_DATA;
`endif
    end else if (data_pend) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes the CPU's instruction and data memory ports
// onto one physical memory port. Each CPU request yields exactly one
// downstream transaction and one single-cycle *_resp pulse.
//
// Configuration macro: DATA_PRIORITY_EN (data-priority tie-break with a
// starvation limit of STARVE_LIMIT consecutive data grants).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   inst_mem_*                instruction port (address/read/write/byte_enable/
//                             wdata in, rdata/resp out)
//   data_mem_*                data port, same shape
//   pmem_address/read/write/  downstream request, held until pmem_resp
//   byte_enable/wdata
//   pmem_rdata, pmem_resp     downstream completion
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_mem_address,
  input  logic        inst_mem_read,
  input  logic        inst_mem_write,
  input  logic [3:0]  inst_mem_byte_enable,
  input  logic [31:0] inst_mem_wdata,
  output logic [31:0] inst_mem_rdata,
  output logic        inst_mem_resp,
  input  logic [31:0] data_mem_address,
  input  logic        data_mem_read,
  input  logic        data_mem_write,
  input  logic [3:0]  data_mem_byte_enable,
  input  logic [31:0] data_mem_wdata,
  output logic [31:0] data_mem_rdata,
  output logic        data_mem_resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  arb_state_t state, state_next;
  arb_port_t  grant;
  mem_req_t   inst_req, data_req, win_req, cur_req;
  logic       inst_pend, data_pend, start;

  assign inst_pend = inst_mem_read | inst_mem_write;
  assign data_pend = data_mem_read | data_mem_write;
  assign start     = (state == IDLE) && (inst_pend || data_pend);

  assign inst_req = pack_req(inst_mem_address, inst_mem_byte_enable,
                             inst_mem_wdata, inst_mem_write);
  assign data_req = pack_req(data_mem_address, data_mem_byte_enable,
                             data_mem_wdata, data_mem_write);
  assign win_req  = (grant == PORT_DATA) ? data_req : inst_req;

`ifdef DATA_PRIORITY_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Consecutive data grants made while the instruction port was waiting.
  logic [CNT_W-1:0] starve_cnt;

  mem_arb_select u_select (
    .inst_pend (inst_pend),
    .data_pend (data_pend),
    .at_limit  (starve_cnt == CNT_W'(STARVE_LIMIT)),
    .grant     (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (start) begin
      if (grant == PORT_DATA && inst_pend) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  // Reset to DATA so the first tie after reset goes to the instruction port.
  arb_port_t last_grant;

  mem_arb_select u_select (
    .inst_pend  (inst_pend),
    .data_pend  (data_pend),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_grant <= PORT_DATA;
    else if (start) last_grant <= grant;
  end
`endif

  // NOTE: registers use non-blocking assignments so every flop updates from
  // values sampled before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = (grant == PORT_DATA) ? BUSY_DATA : BUSY_INST;
      BUSY_INST: if (pmem_resp) state_next = DONE_INST;
      BUSY_DATA: if (pmem_resp) state_next = DONE_DATA;
      DONE_INST: state_next = IDLE;
      DONE_DATA: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The transaction is latched at grant, so a CPU that drops or changes its
  // request mid-transaction cannot disturb the downstream port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_req        <= '0;
      pmem_read      <= 1'b0;
      pmem_write     <= 1'b0;
      inst_mem_rdata <= '0;
      data_mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_req    <= win_req;
            pmem_write <= win_req.write;
            pmem_read  <= ~win_req.write;
          end
        end
        BUSY_INST: begin
          if (pmem_resp) begin
            inst_mem_rdata <= pmem_rdata;
            pmem_read      <= 1'b0;
            pmem_write     <= 1'b0;
          end
        end
        BUSY_DATA: begin
          if (pmem_resp) begin
            data_mem_rdata <= pmem_rdata;
            pmem_read      <= 1'b0;
            pmem_write     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pmem_address     = cur_req.address;
  assign pmem_byte_enable = cur_req.byte_enable;
  assign pmem_wdata       = cur_req.wdata;

  assign inst_mem_resp = (state == DONE_INST);
  assign data_mem_resp = (state == DONE_DATA);

endmodule
